// File: rtl/seven_segment_reader.sv
// -----------------------------------------------------------------------------
// seven_segment_reader
//
// Receive end of a multiplexed seven-segment display bus. The segment,
// decimal-point and digit-enable lines of a scanned NDIGITS display are
// synchronised, filtered for stability and decoded back into BCD. One full
// scan (digit 0 first, ascending) is presented as a frame with a one-cycle
// frame_valid strobe.
//
// Optional build macro:
//   COMMON_ANODE_EN  - when defined, seg/dp/digit_en are active-low and are
//                      inverted before the synchroniser. Undefined (default)
//                      means common-cathode, active-high lines.
//
// Parameters:
//   NDIGITS        number of multiplexed digits (2..8)
//   STABLE_CYCLES  cycles a pattern must hold before it is captured (>=2)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   seg[6:0]     segment lines, seg[6]=A .. seg[0]=G (asynchronous)
//   dp           decimal-point line (asynchronous)
//   digit_en     digit select, expected one-hot (asynchronous)
//   bcd          recovered codes, digit i in bcd[4i+3:4i]
//   dp_out       recovered decimal points
//   frame_valid  one-cycle strobe, bcd/dp_out/frame_err just updated
//   frame_err    last frame held an unrecognised segment pattern
// -----------------------------------------------------------------------------
module seven_segment_reader #(
    parameter int NDIGITS       = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [6:0]             seg,
    input  logic                   dp,
    input  logic [NDIGITS-1:0]     digit_en,
    output logic [4*NDIGITS-1:0]   bcd,
    output logic [NDIGITS-1:0]     dp_out,
    output logic                   frame_valid,
    output logic                   frame_err
);

    localparam int VEC_W = 8 + NDIGITS;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDX_W = $clog2(NDIGITS);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    typedef enum logic [1:0] {
        SYNC_WAIT,
        COLLECT,
        EMIT
    } stateT;

    // Segment pattern {A..G} to code; 4'hF flags an unrecognised pattern.
    function automatic logic [3:0] decodeSeg(input logic [6:0] s);
        logic [3:0] code;
        case (s)
            7'b1111110: code = 4'h0;
            7'b0110000: code = 4'h1;
            7'b1101101: code = 4'h2;
            7'b1111001: code = 4'h3;
            7'b0110011: code = 4'h4;
            7'b1011011: code = 4'h5;
            7'b1011111: code = 4'h6;
            7'b1110000: code = 4'h7;
            7'b1111111: code = 4'h8;
            7'b1111011: code = 4'h9;
            7'b0000001: code = 4'hA;
            7'b0000000: code = 4'hB;
            default:    code = 4'hF;
        endcase
        return code;
    endfunction

    // Saturating increment for the stability counter.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (c == CNT_SAT) ? c : c + CNT_W'(1);
    endfunction

    // Position of the set bit of a one-hot enable vector.
    function automatic logic [IDX_W-1:0] digitIndex(input logic [NDIGITS-1:0] en);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (en[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    logic [VEC_W-1:0] pinVec;
    logic [VEC_W-1:0] syncVec_p0;
    logic [VEC_W-1:0] syncVec_p1;
    logic [VEC_W-1:0] prevVec_p2;
    logic [CNT_W-1:0] stableCnt;
    logic             vld_p2;

    logic [NDIGITS-1:0] capEn;
    logic [6:0]         capSeg;
    logic               capDp;
    logic [3:0]         capCode;
    logic               capBad;
    logic [IDX_W-1:0]   capIdx;
    logic               capOk;

    stateT              state;
    logic [IDX_W-1:0]   expected;
    logic [4*NDIGITS-1:0] shadowBcd;
    logic [NDIGITS-1:0] shadowDp;
    logic               errFlag;
    logic [4*NDIGITS-1:0] insertBcd;
    logic [NDIGITS-1:0] insertDp;

    // ---- Polarity normalisation (combinational, ahead of the synchroniser)
`ifdef COMMON_ANODE_EN
    assign pinVec = ~{digit_en, dp, seg};
`else
    assign pinVec = {digit_en, dp, seg};
`endif

    // ---- Stage p0/p1: two-flop synchroniser; p2: previous-sample register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncVec_p0 <= '0;
            syncVec_p1 <= '0;
            prevVec_p2 <= '0;
        end else begin
            syncVec_p0 <= pinVec;
            syncVec_p1 <= syncVec_p0;
            prevVec_p2 <= syncVec_p1;
        end
    end

    // ---- Stability filter: counts cycles the synchronised vector held still
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stableCnt <= '0;
        end else if (syncVec_p1 != prevVec_p2) begin
            stableCnt <= '0;
        end else begin
            stableCnt <= satInc(stableCnt);
        end
    end

    // Fires only on the single step into saturation, so a held pattern is
    // captured exactly once.
    assign vld_p2 = (syncVec_p1 == prevVec_p2) && (stableCnt == CNT_PRE);

    // ---- Capture decode
    assign capEn   = prevVec_p2[VEC_W-1:8];
    assign capDp   = prevVec_p2[7];
    assign capSeg  = prevVec_p2[6:0];
    assign capCode = decodeSeg(capSeg);
    assign capBad  = (capCode == 4'hF);
    assign capIdx  = digitIndex(capEn);
    // Blanking (no enable) or overlapping enables are not a valid digit.
    assign capOk   = vld_p2 && $onehot(capEn);

    // Shadow frame with the captured digit merged in.
    always_comb begin
        insertBcd = shadowBcd;
        insertDp  = shadowDp;
        for (int i = 0; i < NDIGITS; i++) begin
            if (capIdx == IDX_W'(i)) begin
                insertBcd[4*i +: 4] = capCode;
                insertDp[i]         = capDp;
            end
        end
    end

    // ---- Frame assembly FSM. Outputs load on the capture edge of the last
    //      digit so that frame_valid is high during the EMIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SYNC_WAIT;
            expected    <= '0;
            shadowBcd   <= '0;
            shadowDp    <= '0;
            errFlag     <= 1'b0;
            bcd         <= '0;
            dp_out      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            case (state)
                SYNC_WAIT: begin
                    if (capOk && (capIdx == '0)) begin
                        shadowBcd <= insertBcd;
                        shadowDp  <= insertDp;
                        errFlag   <= capBad;
                        expected  <= IDX_W'(1);
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (capOk) begin
                        if (capIdx == expected) begin
                            shadowBcd <= insertBcd;
                            shadowDp  <= insertDp;
                            errFlag   <= errFlag | capBad;
                            expected  <= expected + IDX_W'(1);
                            if (capIdx == LAST_IDX) begin
                                bcd         <= insertBcd;
                                dp_out      <= insertDp;
                                frame_err   <= errFlag | capBad;
                                frame_valid <= 1'b1;
                                state       <= EMIT;
                            end
                        end else if (capIdx == '0) begin
                            shadowBcd <= insertBcd;
                            shadowDp  <= insertDp;
                            errFlag   <= capBad;
                            expected  <= IDX_W'(1);
                        end else begin
                            state <= SYNC_WAIT;
                        end
                    end
                end
                EMIT: begin
                    state <= SYNC_WAIT;
                end
                default: begin
                    state <= SYNC_WAIT;
                end
            endcase
        end
    end

endmodule
